// File: rtl/inst_fetch_unit.sv
// Instruction-fetch stage: owns the fetch pointer, issues in-order word reads
// to instruction memory, buffers returned words tagged with their PC in a small
// prefetch FIFO, and hands them to decode. A redirect flushes the buffer and
// marks every request still in flight as stale so its response is discarded.
//
// Handshakes: both channels use strict valid/ready. A transfer happens on a
// rising edge where valid and ready are both high. A valid source holds its
// payload stable until the transfer. The memory response channel has no
// backpressure: every imem_resp_valid cycle carries exactly one in-order word.
module inst_fetch_unit #(
  parameter int unsigned       ADDR_W     = 32,
  parameter int unsigned       DATA_W     = 32,
  parameter int unsigned       FIFO_DEPTH = 4,
  parameter logic [ADDR_W-1:0] RESET_PC   = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              imem_req_valid,
  output logic [ADDR_W-1:0] imem_req_addr,
  input  logic              imem_req_ready,
  input  logic              imem_resp_valid,
  input  logic [DATA_W-1:0] imem_resp_data,
  output logic              if_valid,
  output logic [DATA_W-1:0] if_inst,
  output logic [ADDR_W-1:0] if_pc,
  input  logic              if_ready,
  output logic [ADDR_W-1:0] fetch_pc
);

  localparam int unsigned       PW      = $clog2(FIFO_DEPTH);
  localparam int unsigned       CW      = PW + 1;
  localparam logic [CW-1:0]     DEPTH_C = CW'(FIFO_DEPTH);
  localparam logic [ADDR_W-1:0] STEP    = ADDR_W'(4);

  typedef struct packed {
    logic [ADDR_W-1:0] pc;
    logic [DATA_W-1:0] inst;
  } entry_t;

  // Fetch pointer, PC of the next kept response, and credit/drop counters
  logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
  logic [ADDR_W-1:0] resp_pc_q, resp_pc_d;
  logic [CW-1:0]     out_q, out_d;
  logic [CW-1:0]     drop_q, drop_d;

  // Prefetch FIFO storage and pointers
  entry_t            mem_q [FIFO_DEPTH];
  logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]     count_q, count_d;

  logic              fifo_empty;
  logic              req_fire;
  logic              push;
  logic              pop;
  logic [CW:0]       credit_used;
  logic [ADDR_W-1:0] redirect_tgt;
  logic              unused_redirect_lsbs;

  // Low address bits of a redirect target are forced to a word boundary
  assign redirect_tgt         = {redirect_pc[ADDR_W-1:2], 2'b00};
  assign unused_redirect_lsbs = ^redirect_pc[1:0];

  // Request channel: a new request needs a free FIFO slot for its eventual response
  always_comb begin
    fifo_empty     = (count_q == '0);
    credit_used    = {1'b0, out_q} + {1'b0, count_q};
    imem_req_valid = !rst && !redirect_valid && (credit_used < {1'b0, DEPTH_C});
    imem_req_addr  = fetch_pc_q;
    fetch_pc       = fetch_pc_q;
    req_fire       = imem_req_valid && imem_req_ready;
  end

  // Decode channel and FIFO push/pop strobes; responses reach decode only via the FIFO registers
  always_comb begin
    if_valid = !fifo_empty && !redirect_valid;
    if_inst  = fifo_empty ? '0 : mem_q[rd_ptr_q].inst;
    if_pc    = fifo_empty ? '0 : mem_q[rd_ptr_q].pc;
    pop      = if_valid && if_ready;
    push     = imem_resp_valid && !redirect_valid && (drop_q == '0);
  end

  // Next-state: a redirect overrides issue, pop and push for that cycle
  always_comb begin
    fetch_pc_d = fetch_pc_q;
    resp_pc_d  = resp_pc_q;
    out_d      = out_q + CW'(req_fire) - CW'(imem_resp_valid);
    drop_d     = drop_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    if (redirect_valid) begin
      fetch_pc_d = redirect_tgt;
      resp_pc_d  = redirect_tgt;
      // Every request physically in flight is now stale, including any already
      // marked by an earlier redirect; this cycle's response is consumed here.
      drop_d     = out_q - CW'(imem_resp_valid);
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      count_d    = '0;
    end else begin
      if (req_fire) begin
        fetch_pc_d = fetch_pc_q + STEP;
      end
      if (imem_resp_valid) begin
        if (drop_q != '0) begin
          drop_d = drop_q - CW'(1);
        end else begin
          resp_pc_d = resp_pc_q + STEP;
        end
      end
      if (push) begin
        wr_ptr_d = wr_ptr_q + PW'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PW'(1);
      end
      count_d = count_q + CW'(push) - CW'(pop);
    end
  end

  // Control state register with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc_q <= RESET_PC;
      resp_pc_q  <= RESET_PC;
      out_q      <= '0;
      drop_q     <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      resp_pc_q  <= resp_pc_d;
      out_q      <= out_d;
      drop_q     <= drop_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
    end
  end

  // FIFO storage write; contents need no reset because count_q gates visibility
  always_ff @(posedge clk) begin
    if (!rst && push) begin
      mem_q[wr_ptr_q] <= {resp_pc_q, imem_resp_data};
    end
  end

  // The credit rule must keep every kept response within FIFO capacity
  always_ff @(posedge clk) begin
    if (!rst && push) begin
      assert (count_q != DEPTH_C);
    end
  end

endmodule

// File: tb/tb_inst_fetch_unit.sv
// Bench for inst_fetch_unit: a vector table for request/credit/redirect/reset
// behaviour with the memory silent, then directed and random sequences run
// against an in-order latency memory model and an expected-instruction queue.
module tb_inst_fetch_unit;

  localparam logic [31:0] R = 32'hFFFF_FFF8;

  logic        clk = 1'b0;
  logic        rst;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        imem_req_valid;
  logic [31:0] imem_req_addr;
  logic        imem_req_ready;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_data;
  logic        if_valid;
  logic [31:0] if_inst;
  logic [31:0] if_pc;
  logic        if_ready;
  logic [31:0] fetch_pc;

  inst_fetch_unit #(
    .ADDR_W(32), .DATA_W(32), .FIFO_DEPTH(4), .RESET_PC(R)
  ) dut (
    .clk(clk), .rst(rst),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .imem_req_valid(imem_req_valid), .imem_req_addr(imem_req_addr),
    .imem_req_ready(imem_req_ready),
    .imem_resp_valid(imem_resp_valid), .imem_resp_data(imem_resp_data),
    .if_valid(if_valid), .if_inst(if_inst), .if_pc(if_pc), .if_ready(if_ready),
    .fetch_pc(fetch_pc)
  );

  // clock
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // scoreboard: expected {pc, inst} in FIFO order
  logic [63:0] exp_q[$];
  // memory model: in-flight requests with due cycle and issue epoch
  logic [31:0] mq_addr[$];
  int          mq_due[$];
  int          mq_ep[$];

  int          cyc = 0;
  int          epoch = 0;
  int          lat = 1;
  int          rdy_pct = 100;
  int          ifr_pct = 100;
  int          n_req = 0;
  int          n_pop = 0;
  logic [31:0] exp_addr = R;
  logic [31:0] first_pc = '0;
  bit          want_first = 1'b0;

  typedef struct {
    logic        rst;
    logic        rv;
    logic [31:0] rpc;
    logic        rdy;
    logic        e_valid;
    logic [31:0] e_addr;
  } vec_t;

  vec_t tbl[12];

  function automatic logic [31:0] data_of(input logic [31:0] a);
    return a ^ 32'h5A5A_C3C3;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // one clock cycle of traffic; called just after a falling edge
  task automatic cycle(input bit redir, input logic [31:0] rpc);
    bit          resp;
    bit          kept;
    logic [31:0] raddr;
    int          inflight;
    int          ep;
    rst            = 1'b0;
    redirect_valid = redir;
    redirect_pc    = rpc;
    imem_req_ready = ($urandom_range(99) < rdy_pct);
    if_ready       = ($urandom_range(99) < ifr_pct);
    resp  = (mq_addr.size() != 0) && (mq_due[0] <= cyc);
    kept  = 1'b0;
    raddr = '0;
    if (resp) begin
      raddr = mq_addr.pop_front();
      void'(mq_due.pop_front());
      ep    = mq_ep.pop_front();
      kept  = (ep == epoch) && !redir;
      imem_resp_valid = 1'b1;
      imem_resp_data  = data_of(raddr);
    end else begin
      imem_resp_valid = 1'b0;
      imem_resp_data  = $urandom;
    end
    inflight = mq_addr.size() + (resp ? 1 : 0);
    #1;
    chk("fetch_pc", fetch_pc, exp_addr);
    chk("req_valid", imem_req_valid, !redir && ((inflight + exp_q.size()) < 4));
    chk("if_valid", if_valid, !redir && (exp_q.size() != 0));
    if (if_valid && exp_q.size() != 0) begin
      chk("if_head", {if_pc, if_inst}, exp_q[0]);
      if (if_ready) begin
        void'(exp_q.pop_front());
        n_pop++;
        if (want_first) begin
          first_pc   = if_pc;
          want_first = 1'b0;
        end
      end
    end
    if (imem_req_valid && imem_req_ready) begin
      chk("req_addr", imem_req_addr, exp_addr);
      mq_addr.push_back(imem_req_addr);
      mq_due.push_back(cyc + lat);
      mq_ep.push_back(epoch);
      exp_addr = exp_addr + 32'd4;
      n_req++;
    end
    if (redir) begin
      exp_q.delete();
      epoch++;
      exp_addr   = {rpc[31:2], 2'b00};
      want_first = 1'b1;
    end
    if (kept) exp_q.push_back({raddr, data_of(raddr)});
    @(posedge clk);
    cyc++;
    @(negedge clk);
  endtask

  // synchronous reset of DUT and memory model
  task automatic do_reset();
    rst             = 1'b1;
    redirect_valid  = 1'b0;
    redirect_pc     = '0;
    imem_req_ready  = 1'($urandom_range(1));
    imem_resp_valid = 1'b0;
    if_ready        = 1'b1;
    #1;
    chk("rst_req_valid", imem_req_valid, 1'b0);
    @(posedge clk);
    cyc++;
    @(negedge clk);
    rst = 1'b0;
    exp_q.delete();
    mq_addr.delete();
    mq_due.delete();
    mq_ep.delete();
    epoch++;
    exp_addr   = R;
    want_first = 1'b1;
    n_req      = 0;
    n_pop      = 0;
    #1;
    chk("post_rst_if_valid", if_valid, 1'b0);
    chk("post_rst_fetch_pc", fetch_pc, R);
    chk("post_rst_if_pc", if_pc, 32'h0);
    chk("post_rst_if_inst", if_inst, 32'h0);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, '0);
  endtask

  initial begin
    rst = 1'b1; redirect_valid = 1'b0; redirect_pc = '0;
    imem_req_ready = 1'b0; imem_resp_valid = 1'b0; imem_resp_data = '0; if_ready = 1'b0;

    // table: memory never responds, so credit is consumed by outstanding requests only
    tbl[0]  = '{1'b1, 1'b0, 32'h0,    1'b1, 1'b0, R};
    tbl[1]  = '{1'b0, 1'b0, 32'h0,    1'b0, 1'b1, R};
    tbl[2]  = '{1'b0, 1'b0, 32'h0,    1'b1, 1'b1, R};
    tbl[3]  = '{1'b0, 1'b0, 32'h0,    1'b1, 1'b1, 32'hFFFF_FFFC};
    tbl[4]  = '{1'b0, 1'b0, 32'h0,    1'b1, 1'b1, 32'h0000_0000};
    tbl[5]  = '{1'b0, 1'b1, 32'h203,  1'b1, 1'b0, 32'h0000_0004};
    tbl[6]  = '{1'b0, 1'b0, 32'h0,    1'b1, 1'b1, 32'h0000_0200};
    tbl[7]  = '{1'b0, 1'b0, 32'h0,    1'b1, 1'b0, 32'h0000_0204};
    tbl[8]  = '{1'b0, 1'b1, 32'h1007, 1'b1, 1'b0, 32'h0000_0204};
    tbl[9]  = '{1'b0, 1'b0, 32'h0,    1'b0, 1'b0, 32'h0000_1004};
    tbl[10] = '{1'b1, 1'b0, 32'h0,    1'b1, 1'b0, 32'h0000_1004};
    tbl[11] = '{1'b0, 1'b0, 32'h0,    1'b0, 1'b1, R};

    @(negedge clk);
    for (int i = 0; i < 12; i++) begin
      rst            = tbl[i].rst;
      redirect_valid = tbl[i].rv;
      redirect_pc    = tbl[i].rpc;
      imem_req_ready = tbl[i].rdy;
      #1;
      chk($sformatf("tbl%0d_req_valid", i), imem_req_valid, tbl[i].e_valid);
      chk($sformatf("tbl%0d_req_addr", i), imem_req_addr, tbl[i].e_addr);
      chk($sformatf("tbl%0d_fetch_pc", i), fetch_pc, tbl[i].e_addr);
      chk($sformatf("tbl%0d_if_valid", i), if_valid, 1'b0);
      @(posedge clk);
      cyc++;
      @(negedge clk);
    end

    // continuous flow from RESET_PC across the address wrap
    do_reset();
    lat = 1; rdy_pct = 100; ifr_pct = 100;
    run(12);
    chk("flow_n_req", n_req, 12);
    chk("flow_n_pop", n_pop, 10);
    chk("flow_first_pc", first_pc, R);

    // decode stalled: exactly FIFO_DEPTH requests, head held, then drain
    do_reset();
    lat = 1; rdy_pct = 100; ifr_pct = 0;
    run(20);
    chk("stall_n_req", n_req, 4);
    ifr_pct = 100;
    run(10);
    chk("stall_n_pop", n_pop >= 4, 1'b1);

    // latency 3, two requests in flight, unaligned redirect target
    do_reset();
    lat = 3; rdy_pct = 100; ifr_pct = 100;
    run(2);
    chk("redir_inflight", mq_addr.size(), 2);
    cycle(1'b1, 32'h0000_1003);
    run(12);
    chk("redir_first_pc", first_pc, 32'h0000_1000);

    // redirect coinciding with a response and a pending pop
    do_reset();
    lat = 2; rdy_pct = 100; ifr_pct = 0;
    for (int i = 0; i < 20; i++) begin
      if (exp_q.size() != 0 && mq_addr.size() != 0 && mq_due[0] <= cyc) break;
      cycle(1'b0, '0);
    end
    chk("coinc_setup", (exp_q.size() != 0) && (mq_addr.size() != 0) && (mq_due[0] <= cyc), 1'b1);
    ifr_pct = 100;
    cycle(1'b1, 32'h0000_0040);
    chk("coinc_empty_next", if_valid, 1'b0);
    run(12);
    chk("coinc_first_pc", first_pc, 32'h0000_0040);

    // reset in the middle of traffic
    do_reset();
    lat = 2; rdy_pct = 100; ifr_pct = 0;
    for (int i = 0; i < 20; i++) begin
      if (exp_q.size() >= 2 && mq_addr.size() >= 1) break;
      cycle(1'b0, '0);
    end
    chk("midrst_setup", (exp_q.size() >= 2) && (mq_addr.size() >= 1), 1'b1);
    do_reset();
    lat = 2; rdy_pct = 100; ifr_pct = 100;
    run(10);
    chk("midrst_first_pc", first_pc, R);

    // random traffic with random latency, stalls and redirects
    do_reset();
    for (int i = 0; i < 400; i++) begin
      if (i % 50 == 0) begin
        lat     = $urandom_range(4, 1);
        rdy_pct = $urandom_range(100, 40);
        ifr_pct = $urandom_range(100, 30);
      end
      if ($urandom_range(99) < 5) cycle(1'b1, $urandom);
      else cycle(1'b0, '0);
    end

    // drain everything still buffered or in flight
    rdy_pct = 0; ifr_pct = 100;
    for (int i = 0; i < 100; i++) begin
      if (exp_q.size() == 0 && mq_addr.size() == 0) break;
      cycle(1'b0, '0);
    end
    chk("drain_done", (exp_q.size() == 0) && (mq_addr.size() == 0), 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
